demux_1to2_buf: RTL



---
 rtl/demux_1to2_buf_pkg.sv | 25 ++
 rtl/demux_1to2_buf_slot.sv | 127 ++++++++++++
 rtl/demux_1to2_buf.sv | 78 +++++++
 3 files changed

// File: rtl/demux_1to2_buf_pkg.sv
// ---------------------------------------------------------------------------
// demux_1to2_buf_pkg
// Shared constants and types for the registered 1-to-2 demultiplexer.
//   SEL_OUT0 / SEL_OUT1 : in_sel encodings for the two destinations.
//   DEMUX_DEPTH         : entries per output channel (1, or 2 when the
//                         DEMUX_SKID_EN macro is defined).
//   slot_state_e        : one-entry slot state (EMPTY / FULL).
// ---------------------------------------------------------------------------
package demux_1to2_buf_pkg;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

`ifdef DEMUX_SKID_EN
  localparam int DEMUX_DEPTH = 2;
`else
  localparam int DEMUX_DEPTH = 1;
`endif

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_1to2_buf_slot.sv
// ---------------------------------------------------------------------------
// demux_1to2_buf_slot
// One output channel buffer of the demultiplexer.
// Configuration macro: DEMUX_SKID_EN
//   undefined : one-entry slot (EMPTY/FULL), ready_for_load is combinational
//               (empty, or draining this cycle).
//   defined   : two-entry FIFO, ready_for_load is a registered (count != 2).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   load            : write load_data into the buffer this cycle
//   load_data [N:1] : payload to store
//   out_ready       : consumer accepts the head entry this cycle
//   out_valid       : buffer holds data (head entry presented on out_data)
//   out_data [N:1]  : head payload, held stable while stalled
//   ready_for_load  : a load this cycle is allowed
//   count [1:0]     : number of occupied entries (debug/state visibility)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and the producer keeps the
// payload stable while valid && !ready.
// ---------------------------------------------------------------------------
module demux_1to2_buf_slot
  import demux_1to2_buf_pkg::*;
#(
  parameter int N = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [N:1] load_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [N:1] out_data,
  output logic       ready_for_load,
  output logic [1:0] count
);

  logic drain;

`ifdef DEMUX_SKID_EN

  logic [N:1] mem [0:DEMUX_DEPTH-1];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic [1:0] cnt_next;
  logic       rdy_q;

  assign out_valid      = (cnt != 2'd0);
  assign drain          = out_valid && out_ready;
  assign out_data       = mem[rd_ptr];
  assign ready_for_load = rdy_q;
  assign count          = cnt;

  always_comb begin
    cnt_next = cnt;
    case ({load, drain})
      2'b10:   cnt_next = cnt + 2'd1;
      2'b01:   cnt_next = cnt - 2'd1;
      default: cnt_next = cnt;   // idle, or load+drain keeps the count
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      rdy_q  <= 1'b1;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (load) begin
        mem[wr_ptr] <= load_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (drain) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt   <= cnt_next;
      // Registered readiness cuts the out_ready -> in_ready path; a slot
      // that just became full refuses loads even if it drains next cycle.
      rdy_q <= (cnt_next != 2'd2);
    end
  end

`else

  slot_state_e state;
  logic [N:1]  data_q;

  assign out_valid      = (state == SLOT_FULL);
  assign drain          = out_valid && out_ready;
  assign out_data       = data_q;
  // Loadable when empty, or when the current entry leaves this cycle.
  assign ready_for_load = (state == SLOT_EMPTY) || out_ready;
  assign count          = {1'b0, (state == SLOT_FULL)};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SLOT_EMPTY;
      data_q <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: begin
          if (load) begin
            state  <= SLOT_FULL;
            data_q <= load_data;
          end
        end
        SLOT_FULL: begin
          if (load) begin
            // drain+load replaces the entry with no bubble
            state  <= SLOT_FULL;
            data_q <= load_data;
          end else if (drain) begin
            state <= SLOT_EMPTY;
          end
        end
        default: state <= SLOT_EMPTY;
      endcase
    end
  end

`endif

endmodule

// File: rtl/demux_1to2_buf.sv
// ---------------------------------------------------------------------------
// demux_1to2_buf
// Registered 1-to-2 demultiplexer: routes one valid/ready stream to out0 or
// out1 according to in_sel. Each output owns its own buffer, so a stalled
// consumer only blocks transfers addressed to it.
// Configuration macro: DEMUX_SKID_EN (two-entry buffers with registered
// in_ready); undefined gives one-entry buffers with combinational in_ready.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   in_valid/in_ready/in_sel/in_data : input stream, in_sel picks destination
//   out0_valid/out0_ready/out0_data  : destination 0
//   out1_valid/out1_ready/out1_data  : destination 1
//   busy                             : any output buffer occupied
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and the producer keeps the
// payload stable while valid && !ready.
// ---------------------------------------------------------------------------
module demux_1to2_buf
  import demux_1to2_buf_pkg::*;
#(
  parameter int N = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sel,
  input  logic [N:1] in_data,
  output logic       out0_valid,
  input  logic       out0_ready,
  output logic [N:1] out0_data,
  output logic       out1_valid,
  input  logic       out1_ready,
  output logic [N:1] out1_data,
  output logic       busy
);

  logic       load0;
  logic       load1;
  logic       rdy0;
  logic       rdy1;
  logic [1:0] count0;
  logic [1:0] count1;
  logic       accept;

  // in_ready looks only at the selected channel, never at in_valid.
  assign in_ready = (in_sel == SEL_OUT1) ? rdy1 : rdy0;
  assign accept   = in_valid && in_ready;
  assign load0    = accept && (in_sel == SEL_OUT0);
  assign load1    = accept && (in_sel == SEL_OUT1);
  assign busy     = (count0 != 2'd0) || (count1 != 2'd0);

  demux_1to2_buf_slot #(.N(N)) u_slot0 (
    .clk            (clk),
    .rst            (rst),
    .load           (load0),
    .load_data      (in_data),
    .out_ready      (out0_ready),
    .out_valid      (out0_valid),
    .out_data       (out0_data),
    .ready_for_load (rdy0),
    .count          (count0)
  );

  demux_1to2_buf_slot #(.N(N)) u_slot1 (
    .clk            (clk),
    .rst            (rst),
    .load           (load1),
    .load_data      (in_data),
    .out_ready      (out1_ready),
    .out_valid      (out1_valid),
    .out_data       (out1_data),
    .ready_for_load (rdy1),
    .count          (count1)
  );

endmodule
